// File: rtl/ifetch_unit_pkg.sv
// Shared constants and helpers for the instruction fetch stage:
// opcodes, BHT counter reset value, and the saturating counter update.
package ifetch_unit_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Weakly not-taken
    localparam logic [1:0] BHT_INIT = 2'b01;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        NEXT_SEQ,
        NEXT_JAL,
        NEXT_BRANCH
    } next_sel_e;

    function automatic logic [1:0] bht_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != 2'b11) res = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-to-decoder handshake: one instruction slot with its PC and
// prediction flag, accepted by the consumer through ready.
interface ifetch_unit_if;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred_taken;
    logic        ready;

    modport master (output valid, inst, pc, pred_taken, input ready);
    modport slave  (input valid, inst, pc, pred_taken, output ready);
endinterface

// File: rtl/ifetch_unit_branch_predictor.sv
// Branch history table of 2-bit saturating counters; combinational read of
// the taken bit, registered update.
module branch_predictor
    import ifetch_unit_pkg::*;
#(
    parameter int IDX_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic                rd_taken,
    input  logic                upd_en,
    input  logic [IDX_BITS-1:0] upd_idx,
    input  logic                upd_taken
);

    localparam int N = 1 << IDX_BITS;

    logic [N-1:0] taken_vec;

    // Read sees the counter before any same-cycle update lands
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ctr
            logic [1:0] ctr_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ctr_reg <= BHT_INIT;
                end else if (rdy && upd_en && (upd_idx == IDX_BITS'(gi))) begin
                    ctr_reg <= bht_next(ctr_reg, upd_taken);
                end
            end

            assign taken_vec[gi] = ctr_reg[1];
        end
    endgenerate

    assign rd_taken = taken_vec[rd_idx];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the fetch PC, captures cache hits into a
// single output slot, and predicts the next PC from JAL decode plus the BHT.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          BHT_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    output logic [31:0]          icache_pc,
    input  logic [31:0]          icache_dout,
    input  logic                 icache_enable,
    ifetch_unit_if.master        dec,
    input  logic                 rob_flush,
    input  logic [31:0]          rob_target,
    input  logic                 bu_update,
    input  logic [31:0]          bu_pc,
    input  logic                 bu_taken
);

    logic [31:0] pc_reg;
    logic        valid_reg;
    logic [31:0] inst_reg;
    logic [31:0] slot_pc_reg;
    logic        pred_reg;

    logic        bht_taken;
    logic [6:0]  opcode;
    logic [31:0] imm_j;
    logic [31:0] imm_b;
    next_sel_e   sel_next;
    logic [31:0] next_pc_next;
    logic        pred_next;
    logic        slot_free;
    logic        capture;
    logic        unused_bu_pc;

    assign icache_pc      = pc_reg;
    assign dec.valid      = valid_reg;
    assign dec.inst       = inst_reg;
    assign dec.pc         = slot_pc_reg;
    assign dec.pred_taken = pred_reg;

    // Only the index bits of the resolved branch PC address the table
    assign unused_bu_pc = ^{bu_pc[31:BHT_BITS+2], bu_pc[1:0]};

    branch_predictor #(
        .IDX_BITS (BHT_BITS)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .rd_idx    (pc_reg[BHT_BITS+1:2]),
        .rd_taken  (bht_taken),
        .upd_en    (bu_update),
        .upd_idx   (bu_pc[BHT_BITS+1:2]),
        .upd_taken (bu_taken)
    );

    always_comb begin
        opcode = icache_dout[6:0];
        imm_j  = {{11{icache_dout[31]}}, icache_dout[31], icache_dout[19:12],
                  icache_dout[20], icache_dout[30:21], 1'b0};
        imm_b  = {{19{icache_dout[31]}}, icache_dout[31], icache_dout[7],
                  icache_dout[30:25], icache_dout[11:8], 1'b0};

        sel_next = NEXT_SEQ;
        case (opcode)
            OPC_JAL:    sel_next = NEXT_JAL;
            OPC_BRANCH: sel_next = bht_taken ? NEXT_BRANCH : NEXT_SEQ;
            default:    sel_next = NEXT_SEQ;
        endcase

        next_pc_next = pc_reg + 32'd4;
        pred_next    = FALSE;
        case (sel_next)
            NEXT_JAL: begin
                next_pc_next = pc_reg + imm_j;
                pred_next    = TRUE;
            end
            NEXT_BRANCH: begin
                next_pc_next = pc_reg + imm_b;
                pred_next    = TRUE;
            end
            default: begin
                next_pc_next = pc_reg + 32'd4;
                pred_next    = FALSE;
            end
        endcase
    end

    assign slot_free = !valid_reg || dec.ready;
    assign capture   = icache_enable && slot_free && !rob_flush;

    // Flush outranks capture and accept; PC only moves on a hit or a flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg      <= RESET_PC;
            valid_reg   <= 1'b0;
            inst_reg    <= 32'h0;
            slot_pc_reg <= 32'h0;
            pred_reg    <= 1'b0;
        end else if (rdy) begin
            if (rob_flush) begin
                pc_reg    <= rob_target;
                valid_reg <= 1'b0;
            end else if (capture) begin
                pc_reg      <= next_pc_next;
                valid_reg   <= 1'b1;
                inst_reg    <= icache_dout;
                slot_pc_reg <= pc_reg;
                pred_reg    <= pred_next;
            end else if (dec.ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage directly downstream of the instruction cache. It owns the architectural fetch PC and presents it to the cache as a continuously valid address. It captures the returned instruction, predicts the next PC with static JAL decode plus a 2-bit branch history table, and hands one instruction per cycle to the decoder/instruction queue through a valid/ready handshake. Redirects from the reorder buffer flush the stage and restart fetch at the corrected target.

## Interface
- `RESET_PC`, default 32'h0: fetch PC after reset.
- `BHT_BITS`, default 8: BHT index width. The BHT has 2^BHT_BITS entries, indexed by pc[BHT_BITS+1:2].

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `rdy` in 1: global enable. When low, all state is frozen.
- `icache_pc` out 32: current fetch PC. Driven directly from the PC register, so it is valid every cycle.
- `icache_dout` in 32: instruction returned by the cache for `icache_pc`.
- `icache_enable` in 1: `icache_dout` is valid for the current `icache_pc`.
- `dec_valid` out 1: the output slot holds an instruction.
- `dec_inst` out 32: instruction in the output slot.
- `dec_pc` out 32: PC of that instruction.
- `dec_pred_taken` out 1: the fetch stage redirected after this instruction (JAL, or branch predicted taken).
- `dec_ready` in 1: the consumer accepts the slot this cycle.
- `rob_flush` in 1: mispredict or exception redirect.
- `rob_target` in 32: new fetch PC, used when `rob_flush` is high.
- `bu_update` in 1: a branch has resolved.
- `bu_pc` in 32: PC of the resolved branch.
- `bu_taken` in 1: actual outcome of the resolved branch.

## Operation
- State: the PC register, the output slot (valid, inst, pc, pred_taken), and the BHT of 2-bit saturating counters.
- Slot is free when `!dec_valid || dec_ready`.
- Capture happens when `icache_enable && slot free && !rob_flush`. On capture:
  - the slot loads {1, icache_dout, icache_pc, pred};
  - the PC register loads next_pc.
- next_pc, decoded from opcode inst[6:0]:
  - 7'b1101111 (JAL): pc + sext(immJ), pred = 1.
  - 7'b1100011 (BRANCH): pc + sext(immB) if BHT[idx][1] == 1, pred = 1; otherwise pc + 4, pred = 0.
  - Anything else, including JALR: pc + 4, pred = 0.
- All adds are 32-bit and wrap modulo 2^32.
- Accept without capture (`dec_ready` high, no capture): `dec_valid` drops to 0.
- If no cache hit arrives, the PC is held. The PC never changes while the cache is still filling a line for it, except on a flush.
- Flush has priority over capture and over accept:
  - PC loads `rob_target`;
  - `dec_valid` is cleared;
  - `icache_dout` in that cycle is ignored.
- BHT update when `bu_update` is high: the counter at bu_pc[BHT_BITS+1:2] saturates up if `bu_taken`, down otherwise (00..11).
- Simultaneous BHT update and prediction read of the same index: the prediction uses the pre-update value.
- `rdy` low: no PC, slot, or BHT change. Outputs hold.

## Timing
- Reset (asynchronous, takes effect immediately):
  - `icache_pc` = RESET_PC;
  - `dec_valid` = 0, `dec_inst` = 0, `dec_pc` = 0, `dec_pred_taken` = 0;
  - every BHT counter = 2'b01 (weakly not-taken).
- Reset asserted mid-operation discards the slot and any in-flight cache miss result.
- Latency: a cache hit at edge N appears on `dec_*` with `dec_valid` = 1 after edge N. The new `icache_pc` is visible in the same cycle.
- Throughput: one instruction per cycle on consecutive hits with `dec_ready` held high.
- Handshake:
  - A transfer occurs at a posedge with `dec_valid && dec_ready`.
  - While `dec_valid && !dec_ready`, all `dec_*` outputs and `icache_pc` are stable.
- Flush at edge N: `icache_pc` = rob_target and `dec_valid` = 0 after N. The first instruction from the new path can be captured at edge N+1 at the earliest.

## Structure
- Opcode constants (OPC_JAL, OPC_BRANCH), the BHT counter reset value, and the True/False macros belong in the shared `defines.v`.
- The BHT is a natural sub-module, `branch_predictor`:
  - read port: index → taken bit;
  - update port: index, taken.
- Immediate extraction and next_pc selection stay inline in `ifetch_unit`.

## Test plan
- Reset, hold `icache_enable` high, feed ADDI instructions, keep `dec_ready` = 1 → `dec_pc` = 0, 4, 8, 12 on consecutive cycles; `dec_pred_taken` = 0.
- Feed JAL x0, +16 (32'h0100006F) at pc 0x8 → next `icache_pc` = 0x18 and `dec_pred_taken` = 1.
- Branch BEQ with offset -8 at pc 0x20:
  - fresh BHT → next pc 0x24;
  - after two `bu_update` with taken = 1 for pc 0x20 → the next fetch of 0x20 goes to 0x18;
  - after four more not-taken updates → 0x24 again, with the counter saturated at 00.
- Hold `dec_ready` = 0 for 5 cycles while `icache_enable` = 1 → `dec_*` and `icache_pc` unchanged. Release → transfer occurs, then PC advances.
- Assert `rob_flush` with `rob_target` = 0x100 in the same cycle as a hit and a pending slot → `dec_valid` = 0, `icache_pc` = 0x100, and the hit instruction is never output.
- Drop `rdy` for 3 cycles mid-stream, then assert `rst` asynchronously mid-cycle → no state change while `rdy` = 0; on `rst`, outputs go to reset values immediately.
